adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
Shares one pipelined 16-bit parallel-prefix adder (fixed 7-cycle operand-to-sum latency, no stall or reset) among NUM_REQ requesters. Performs round-robin arbitration with valid/ready handshakes and registers the winning operands into the adder. A tag shift register aligned to the adder latency carries requester IDs. A credit-guarded response FIFO returns results, so the unstallable adder pipe can never overflow the response path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
W, 16, operand width; must equal the adder width
LATENCY, 7, cycles from operands on add_a/add_b to the matching value on add_sum
FIFO_DEPTH, 8, response FIFO entries; must be >= 2
IDW, $clog2(NUM_REQ), requester ID width (derived; not overridden)

Ports:
clk  in  1  clock; all flops rising-edge
rst_n  in  1  reset; asynchronous, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant/accept
req_a  in  NUM_REQ*W  operand A; slice i belongs to requester i
req_b  in  NUM_REQ*W  operand B, packed the same way
req_cin  in  NUM_REQ  carry-in per requester
add_a  out  W  adder operand A (registered)
add_b  out  W  adder operand B (registered)
add_cin  out  1  adder carry-in (registered)
add_sum  in  W  adder sum
add_cout  in  1  adder carry-out (adder cout bit 0)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer accepts
rsp_id  out  IDW  originating requester
rsp_sum  out  W  result sum
rsp_cout  out  1  result carry-out
busy  out  1  high if any op is in the issue register, the tag pipe or the FIFO

Behaviour:
- Reset (async assert, sync release), all values:
  - credits = FIFO_DEPTH; issue_vld = 0; tag pipe valid bits = 0; FIFO empty.
  - rr_last = NUM_REQ-1, so requester 0 has highest priority first.
  - add_a = 0, add_b = 0, add_cin = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, busy = 0; req_ready = 0.
- Arbitration (combinational):
  - Only when credits > 0. Search order starts at rr_last+1 and wraps.
  - The first requester with req_valid set wins; req_ready is one-hot for the winner, all zero otherwise.
  - req_ready depends on req_valid. A requester must not make req_valid depend on req_ready.
  - A request held while not granted must keep its operands stable.
- Grant in cycle k (req_valid[i] & req_ready[i]):
  - At the end of cycle k: add_a, add_b and add_cin load slice i; issue_vld = 1; issue_id = i; rr_last = i; credits decrement.
  - No grant: issue_vld = 0, and operands hold their last value.
- Tag pipe:
  - LATENCY stages carrying {vld, id}. Stage 0 captures {issue_vld, issue_id} while the operands are on add_a.
  - The stage LATENCY-1 output is aligned with add_sum/add_cout, which are valid in cycle k+1+LATENCY.
  - If the tail vld is set, write {id, add_sum, add_cout} into the FIFO at the end of that cycle.
  - add_sum is ignored when the tail vld is clear; the adder output is garbage after reset.
- Response FIFO:
  - First-word-fall-through. rsp_* show the head entry; pop on rsp_valid & rsp_ready.
  - Write and pop in the same cycle are both honoured.
  - Writes never occur when full; the credit scheme guarantees this. An assertion flags any violation.
- Credits:
  - credits = FIFO_DEPTH minus (ops in issue register, tag pipe and FIFO).
  - Grant decrements; pop increments; both in the same cycle leaves credits unchanged.
  - Range 0..FIFO_DEPTH.
- Latency: handshake in cycle k gives rsp_valid in cycle k+2+LATENCY (9 by default) when the FIFO is empty.
- Throughput: one op per cycle while credits last. Responses return in grant order.
- Reset mid-operation: all in-flight ops and FIFO contents are discarded and no response is produced for them. The adder needs no reset.
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin, modulo 2^(W+1), taken from the adder unchanged.

Decomposition:
- Shared package adder_pkg:
  - constants ADD_W = 16 and ADD_LATENCY = 7;
  - typedef add_rsp_t = {id, sum, cout}.
- One sub-module, rr_arbiter (NUM_REQ; inputs req, en, last; output one-hot grant); reusable elsewhere.
- The FIFO and the tag pipe stay inline.

Test Plan:
- Single op: requester 2 presents a=0xFFFF, b=0x0001, cin=0 and is granted in cycle 10 -> rsp_valid in cycle 19 with id=2, sum=0x0000, cout=1; busy falls the cycle after the pop.
- Round-robin: all 4 requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,1…; one grant per cycle; responses arrive in the same order with correct sums.
- Backpressure: rsp_ready=0, all requesters valid -> exactly 8 grants, then req_ready stays 0. Raising rsp_ready pops 8 responses; grants resume only as credits return; the FIFO never overflows.
- Simultaneous grant and pop at credits=0 boundary -> credits stay 0 for that cycle; the next cycle grants 1 op; no lost or duplicate response.
- Reset mid-flight: assert rst_n=0 with 5 ops in flight -> all outputs take reset values immediately; after release no stale rsp_valid ever appears. A new op a=0x1234, b=0x4321, cin=1 returns sum=0x5556, cout=0.
- Carry-in corner: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and the response record for the pipelined-adder sharing block.
// The response ID is sized for the largest supported requester count (8).
package adder_pkg;

    localparam int ADD_W       = 16;
    localparam int ADD_LATENCY = 7;
    localparam int ADD_MAX_IDW = 3;

    typedef struct packed {
        logic [ADD_MAX_IDW-1:0] id;
        logic [ADD_W-1:0]       sum;
        logic                   cout;
    } add_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after last_i,
// searching upward with wrap-around, only while en_i is high.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic           en_i,
    input  logic [IDW-1:0] last_i,
    output logic [N-1:0]   grant_o
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IDW'((int'(last_i) + off) % N);
            if (en_i && !found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one unstallable pipelined adder among NUM_REQ requesters; a credit count
// guarantees every op in flight has a reserved slot in the response FIFO.
module adder_share_arbiter
    import adder_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int W          = ADD_W,
    parameter int LATENCY    = ADD_LATENCY,
    parameter int FIFO_DEPTH = 8,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_cin,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    output logic                 add_cin,
    input  logic [W-1:0]         add_sum,
    input  logic                 add_cout,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_sum,
    output logic                 rsp_cout,
    output logic                 busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_id;
    logic               grant_fire;
    logic [W-1:0]       sel_a, sel_b;
    logic               sel_cin;

    logic [IDW-1:0]     rr_last_q;
    logic [CW-1:0]      credits_q;
    logic [W-1:0]       add_a_q, add_b_q;
    logic               add_cin_q;
    logic               issue_vld_q;
    logic [IDW-1:0]     issue_id_q;

    logic [LATENCY-1:0] tag_vld_q;
    logic [IDW-1:0]     tag_id_q [LATENCY];

    add_rsp_t           mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    add_rsp_t           wr_data, head;
    logic               fifo_wr, fifo_pop, fifo_empty, fifo_full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
        .req_i   (req_valid),
        .en_i    (credits_q != '0),
        .last_i  (rr_last_q),
        .grant_o (grant)
    );

    assign req_ready  = grant;
    assign grant_fire = |grant;

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_id = IDW'(i);
        end
        sel_a   = req_a[int'(grant_id)*W +: W];
        sel_b   = req_b[int'(grant_id)*W +: W];
        sel_cin = req_cin[grant_id];
    end

    // Operands hold their last value when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            issue_vld_q <= 1'b0;
            issue_id_q  <= '0;
            rr_last_q   <= IDW'(NUM_REQ - 1);
        end else begin
            issue_vld_q <= grant_fire;
            if (grant_fire) begin
                add_a_q    <= sel_a;
                add_b_q    <= sel_b;
                add_cin_q  <= sel_cin;
                issue_id_q <= grant_id;
                rr_last_q  <= grant_id;
            end
        end
    end

    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = add_cin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            for (int s = 0; s < LATENCY; s++) tag_id_q[s] <= '0;
        end else begin
            tag_vld_q[0] <= issue_vld_q;
            tag_id_q[0]  <= issue_id_q;
            for (int s = 1; s < LATENCY; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

    always_comb begin
        wr_data      = '0;
        wr_data.id   = ADD_MAX_IDW'(tag_id_q[LATENCY-1]);
        wr_data.sum  = add_sum;
        wr_data.cout = add_cout;
    end

    assign fifo_wr    = tag_vld_q[LATENCY-1];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_pop   = !fifo_empty && rsp_ready;

    // Storage needs no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_wr)  wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (fifo_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({fifo_wr, fifo_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q <= CW'(FIFO_DEPTH);
        end else begin
            case ({grant_fire, fifo_pop})
                2'b10:   credits_q <= credits_q - CW'(1);
                2'b01:   credits_q <= credits_q + CW'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n) assert (!(fifo_wr && fifo_full));
    end

    assign head      = mem_q[rd_ptr_q];
    assign rsp_valid = !fifo_empty;
    assign rsp_id    = fifo_empty ? '0 : IDW'(head.id);
    assign rsp_sum   = fifo_empty ? '0 : head.sum;
    assign rsp_cout  = fifo_empty ? 1'b0 : head.cout;
    assign busy      = (credits_q != CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a 7-stage behavioural adder model
// standing in for the shared prefix adder.
module tb_adder_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_cin;
    logic [15:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_cout, busy;

    int nCompared = 0;
    int nMismatch = 0;
    int grantCount;

    logic [16:0] addPipe [7];
    logic [15:0] expSum  [4] = '{16'h0003, 16'h3001, 16'hFFFF, 16'h0000};
    logic        expCout [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  drainId [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    always #5 clk = ~clk;

    adder_share_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    // Unstallable, unreset adder: operands seen in cycle c show up on add_sum in cycle c+7.
    always @(posedge clk) begin
        addPipe[0] <= {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);
        for (int j = 1; j < 7; j++) addPipe[j] <= addPipe[j-1];
    end
    assign add_sum  = addPipe[6][15:0];
    assign add_cout = addPipe[6][16];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic ready);
        req_valid = valid;
        rsp_ready = ready;
        #2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic [15:0] a, input logic [15:0] b, input logic cin);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_cin[i]        = cin;
    endtask

    task automatic doReset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) nextCycle();
        rst_n = 1'b1;
    endtask

    task automatic checkRsp(input string tag, input logic [1:0] id, input logic [15:0] sum, input logic cout);
        checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'(1'b1));
        checkOutput({tag, "_id"},    32'(rsp_id),    32'(id));
        checkOutput({tag, "_sum"},   32'(rsp_sum),   32'(sum));
        checkOutput({tag, "_cout"},  32'(rsp_cout),  32'(cout));
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        #2 rst_n  = 1'b0;
        repeat (2) nextCycle();

        $display("[TB] reset values");
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        checkOutput("rst_busy",      32'(busy),      32'(0));
        checkOutput("rst_add_a",     32'(add_a),     32'(0));
        checkOutput("rst_req_ready", 32'(req_ready), 32'(0));
        rst_n = 1'b1;
        nextCycle();

        $display("[TB] single op");
        setReq(2, 16'hFFFF, 16'h0001, 1'b0);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("single_ready", 32'(req_ready), 32'(4'b0100));
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("single_add_a", 32'(add_a), 32'h0000_FFFF);
        checkOutput("single_busy",  32'(busy),  32'(1));
        repeat (7) nextCycle();
        checkOutput("single_early", 32'(rsp_valid), 32'(0));
        nextCycle();
        checkRsp("single", 2'd2, 16'h0000, 1'b1);
        nextCycle();
        checkOutput("single_after_valid", 32'(rsp_valid), 32'(0));
        checkOutput("single_after_busy",  32'(busy),      32'(0));

        $display("[TB] round robin");
        doReset();
        setReq(0, 16'h0001, 16'h0002, 1'b0);
        setReq(1, 16'h1000, 16'h2000, 1'b1);
        setReq(2, 16'hFFFF, 16'hFFFF, 1'b1);
        setReq(3, 16'h8000, 16'h8000, 1'b0);
        for (int g = 0; g < 8; g++) begin
            applyStimulus(4'hF, 1'b1);
            checkOutput($sformatf("rr_grant%0d", g), 32'(req_ready), 32'(1) << (g % 4));
            nextCycle();
        end
        applyStimulus(4'hF, 1'b1);
        checkOutput("rr_nocredit", 32'(req_ready), 32'(0));
        nextCycle();
        applyStimulus(4'h0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            checkRsp($sformatf("rr_rsp%0d", r), 2'(r % 4), expSum[r % 4], expCout[r % 4]);
            nextCycle();
        end
        checkOutput("rr_idle_valid", 32'(rsp_valid), 32'(0));
        checkOutput("rr_idle_busy",  32'(busy),      32'(0));

        $display("[TB] backpressure and credit boundary");
        grantCount = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(4'hF, 1'b0);
            if (req_ready != '0) grantCount++;
            nextCycle();
        end
        checkOutput("bp_grants", 32'(grantCount), 32'(8));
        applyStimulus(4'hF, 1'b1);
        checkOutput("bp_pop_ready", 32'(req_ready), 32'(0));
        checkRsp("bp_head", 2'd0, 16'h0003, 1'b0);
        nextCycle();
        applyStimulus(4'hF, 1'b0);
        checkOutput("bp_regrant", 32'(req_ready), 32'(4'b0001));
        nextCycle();
        applyStimulus(4'hF, 1'b0);
        checkOutput("bp_empty_credit", 32'(req_ready), 32'(0));
        nextCycle();
        applyStimulus(4'h0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            checkRsp($sformatf("bp_rsp%0d", r), drainId[r], expSum[drainId[r]], expCout[drainId[r]]);
            nextCycle();
        end
        checkOutput("bp_idle_valid", 32'(rsp_valid), 32'(0));
        checkOutput("bp_idle_busy",  32'(busy),      32'(0));

        $display("[TB] reset mid-flight");
        setReq(1, 16'h1234, 16'h4321, 1'b1);
        setReq(0, 16'hFFFF, 16'h0000, 1'b1);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'hF, 1'b1);
            nextCycle();
        end
        applyStimulus(4'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_add_a",     32'(add_a),     32'(0));
        checkOutput("mid_add_cin",   32'(add_cin),   32'(0));
        checkOutput("mid_busy",      32'(busy),      32'(0));
        checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'(0));
        repeat (2) nextCycle();
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            checkOutput($sformatf("mid_stale%0d", c), 32'(rsp_valid), 32'(0));
            nextCycle();
        end
        applyStimulus(4'b0010, 1'b1);
        checkOutput("post_grant1", 32'(req_ready), 32'(4'b0010));
        nextCycle();
        applyStimulus(4'b0001, 1'b1);
        checkOutput("post_grant0", 32'(req_ready), 32'(4'b0001));
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        repeat (6) nextCycle();
        checkOutput("post_early", 32'(rsp_valid), 32'(0));
        nextCycle();
        checkRsp("post_rsp1", 2'd1, 16'h5556, 1'b0);
        nextCycle();
        checkRsp("post_rsp0", 2'd0, 16'h0000, 1'b1);
        nextCycle();
        checkOutput("post_idle_valid", 32'(rsp_valid), 32'(0));
        checkOutput("post_idle_busy",  32'(busy),      32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
